// File: rtl/wb_burst_master.sv
// wb_burst_master: single-command Wishbone B3 incrementing burst engine (read/write).
// Optional macro WB_BURST_TIMEOUT_EN adds a per-beat ack timeout that aborts the burst and pulses err.
module wb_burst_master #(
    parameter int APP_AW  = 26,
    parameter int APP_DW  = 32,
    parameter int APP_BW  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [APP_AW-1:0] cmd_addr,
    input  logic [7:0]        cmd_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [APP_DW-1:0] wdata,
    input  logic [APP_BW-1:0] wsel,
    output logic              rdata_valid,
    output logic [APP_DW-1:0] rdata,
    output logic              busy,
    output logic              err,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [APP_AW-1:0] wb_addr_o,
    output logic [APP_DW-1:0] wb_dat_o,
    output logic [APP_BW-1:0] wb_sel_o,
    output logic [2:0]        wb_cti_o,
    input  logic              wb_ack_i,
    input  logic [APP_DW-1:0] wb_dat_i
);
    // state  | meaning
    // IDLE   | waiting for a command, cmd_ready high
    // WRITE  | write burst, stb follows the holding register
    // READ   | read burst, stb held high
    // FINISH | one-cycle bus release before IDLE
    typedef enum logic [1:0] {IDLE, WRITE, READ, FINISH} state_t;

    localparam logic [APP_AW-1:0] ADDR_STEP = APP_AW'(APP_BW);
    localparam logic [APP_AW-1:0] ADDR_MASK = ~APP_AW'(APP_BW - 1);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    state_t            state, state_nx;
    logic [APP_AW-1:0] addr_q;
    logic [7:0]        len_q;
    logic [7:0]        beat_cnt;
    logic [8:0]        load_cnt;
    logic              hold_valid;
    logic [APP_DW-1:0] dat_q;
    logic [APP_BW-1:0] sel_q;
    logic [APP_DW-1:0] rdata_q;
    logic              rdata_valid_q;
    logic              active;
    logic              ack;
    logic              last_beat;
    logic              wr_accept;
    logic              abort;

    assign active    = (state == WRITE) || (state == READ);
    assign wb_stb_o  = (state == WRITE) ? hold_valid : (state == READ);
    assign ack       = wb_ack_i && wb_stb_o;
    assign last_beat = (beat_cnt == len_q);
    assign wr_accept = wdata_ready && wdata_valid;

    assign wb_addr_o   = addr_q;
    assign wb_dat_o    = dat_q;
    assign wb_sel_o    = sel_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        cmd_ready   = 1'b0;
        busy        = (state != IDLE);
        wb_cyc_o    = active;
        wb_we_o     = (state == WRITE);
        wb_cti_o    = 3'b000;
        wdata_ready = 1'b0;
        if (active) wb_cti_o = last_beat ? 3'b111 : 3'b010;
        case (state)
            IDLE: begin
                cmd_ready = !sys_rst;
                if (cmd_valid) state_nx = cmd_we ? WRITE : READ;
            end
            WRITE: begin
                // holding register may refill in the same cycle its beat is acked
                wdata_ready = (load_cnt <= {1'b0, len_q}) && (!hold_valid || ack);
                if (ack && last_beat) state_nx = FINISH;
            end
            READ: begin
                if (ack && last_beat) state_nx = FINISH;
            end
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = FINISH;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            addr_q        <= '0;
            len_q         <= '0;
            beat_cnt      <= '0;
            load_cnt      <= '0;
            hold_valid    <= 1'b0;
            dat_q         <= '0;
            sel_q         <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            rdata_valid_q <= (state == READ) && ack;
            if ((state == READ) && ack) rdata_q <= wb_dat_i;
            if (state == IDLE) begin
                if (cmd_valid) begin
                    addr_q     <= cmd_addr & ADDR_MASK;
                    len_q      <= cmd_len;
                    beat_cnt   <= '0;
                    load_cnt   <= '0;
                    hold_valid <= 1'b0;
                end
            end else begin
                if (ack) begin
                    addr_q   <= addr_q + ADDR_STEP;
                    beat_cnt <= beat_cnt + 8'd1;
                end
                if (wr_accept) begin
                    hold_valid <= 1'b1;
                    dat_q      <= wdata;
                    sel_q      <= wsel;
                    load_cnt   <= load_cnt + 9'd1;
                end else if (ack) begin
                    hold_valid <= 1'b0;
                end
                if (abort) hold_valid <= 1'b0;
            end
        end
    end

`ifdef WB_BURST_TIMEOUT_EN
    localparam int               TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             err_q;

    // terminal count reached on the TIMEOUT-th unacked strobe cycle
    assign abort = wb_stb_o && !wb_ack_i && (tmo_cnt == '0);
    assign err   = err_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tmo_cnt <= TMO_LOAD;
            err_q   <= 1'b0;
        end else begin
            err_q <= abort;
            if (ack || abort || !active) tmo_cnt <= TMO_LOAD;
            else if (wb_stb_o)           tmo_cnt <= tmo_cnt - TMO_W'(1);
        end
    end
`else
    assign abort = 1'b0;
    assign err   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_burst_master.sv
// Randomized self-checking bench for wb_burst_master against a beat-list reference model.
// Covers the WB_BURST_TIMEOUT_EN build as well as the default build.
module tb_wb_burst_master;
    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [25:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wdata_valid, wdata_ready;
    logic [31:0] wdata;
    logic [3:0]  wsel;
    logic        rdata_valid;
    logic [31:0] rdata;
    logic        busy, err;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [25:0] wb_addr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [2:0]  wb_cti_o;
    logic        wb_ack_i;
    logic [31:0] wb_dat_i;

    int checks = 0;
    int errors = 0;
    logic [31:0] wdat_arr [256];
    logic [3:0]  wsel_arr [256];

    wb_burst_master #(.APP_AW(26), .APP_DW(32), .APP_BW(4), .TIMEOUT(16)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata), .wsel(wsel),
        .rdata_valid(rdata_valid), .rdata(rdata), .busy(busy), .err(err),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic recover();
        sys_rst = 1'b1;
        #3;
        sys_rst = 1'b0;
        tick();
    endtask

    // present a command in IDLE; returns during the first busy cycle
    task automatic issue_cmd(input logic we, input logic [25:0] a, input logic [7:0] l);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_len = l;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL cmd_ready_idle got %b exp 1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            errors++; $display("FAIL busy_after_cmd got busy=%b ready=%b exp 1/0", busy, cmd_ready);
        end
    endtask

    task automatic run_burst(input logic we, input logic [25:0] a, input logic [7:0] l,
                             input int ack_pct, input int wv_pct, input int gap_beat,
                             input int gap_len, input bit fixed, output int waits);
        logic [25:0] base;
        logic [31:0] rq [$];
        logic [31:0] exp_r;
        int acks, hidx, gapc, rcnt, cyc_n;
        logic prev_ack;
        base = a & ~26'h3;
        acks = 0; hidx = 0; gapc = 0; rcnt = 0; cyc_n = 0; prev_ack = 1'b0; waits = 0;
        for (int i = 0; i < 256; i++) begin
            wdat_arr[i] = fixed ? 32'hA0 + i : $urandom;
            wsel_arr[i] = 4'($urandom);
        end
        issue_cmd(we, a, l);
        while (acks <= int'(l) && cyc_n < 3000) begin
            if (cyc_n > 0) tick();
            if (!we) begin
                checks++;
                if (rdata_valid !== prev_ack) begin
                    errors++; $display("FAIL rdata_valid_timing got %b exp %b", rdata_valid, prev_ack);
                end
                if (rdata_valid === 1'b1 && rq.size() > 0) begin
                    rcnt++;
                    exp_r = rq.pop_front();
                    checks++;
                    if (rdata !== exp_r) begin
                        errors++; $display("FAIL rdata got %h exp %h", rdata, exp_r);
                    end
                end
            end
            wb_ack_i = ($urandom_range(0, 99) < ack_pct);
            wb_dat_i = fixed ? 32'hDEADBEEF : $urandom;
            if (hidx == gap_beat && gapc < gap_len) begin
                wdata_valid = 1'b0; gapc++;
            end else begin
                wdata_valid = ($urandom_range(0, 99) < wv_pct);
            end
            wdata = wdat_arr[hidx % 256];
            wsel  = wsel_arr[hidx % 256];
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_we = 1'($urandom); cmd_addr = 26'($urandom); cmd_len = 8'($urandom);
            #1;
            checks++;
            if (cmd_ready !== 1'b0 || busy !== 1'b1 || wb_cyc_o !== 1'b1 || wb_we_o !== we) begin
                errors++;
                $display("FAIL burst_ctl got ready=%b busy=%b cyc=%b we=%b exp 0/1/1/%b",
                         cmd_ready, busy, wb_cyc_o, wb_we_o, we);
            end
            checks++;
            if (wdata_ready === 1'b1 && (!we || hidx > int'(l))) begin
                errors++; $display("FAIL extra_wdata got ready=1 at index %0d exp 0", hidx);
            end
            if (wb_cyc_o && !wb_stb_o) waits++;
            if (we && wdata_valid && wdata_ready) hidx++;
            prev_ack = wb_ack_i && wb_stb_o;
            if (prev_ack) begin
                checks++;
                if (wb_addr_o !== base + 26'(acks * 4)) begin
                    errors++; $display("FAIL addr beat %0d got %h exp %h", acks, wb_addr_o, base + 26'(acks * 4));
                end
                checks++;
                if (wb_cti_o !== ((acks == int'(l)) ? 3'b111 : 3'b010)) begin
                    errors++; $display("FAIL cti beat %0d got %b", acks, wb_cti_o);
                end
                if (we) begin
                    checks++;
                    if (wb_dat_o !== wdat_arr[acks] || wb_sel_o !== wsel_arr[acks]) begin
                        errors++;
                        $display("FAIL wdat beat %0d got %h/%h exp %h/%h", acks, wb_dat_o, wb_sel_o,
                                 wdat_arr[acks], wsel_arr[acks]);
                    end
                end else begin
                    rq.push_back(wb_dat_i);
                end
                acks++;
            end
            cyc_n++;
        end
        if (acks <= int'(l)) begin
            checks++; errors++;
            $display("FAIL burst_budget got %0d acks exp %0d", acks, l + 1);
            cmd_valid = 1'b0; wb_ack_i = 1'b0; wdata_valid = 1'b0;
            recover();
            return;
        end
        tick();
        wb_ack_i = 1'b0; cmd_valid = 1'b0; wdata_valid = 1'b0;
        #1;
        checks++;
        if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || wb_we_o !== 1'b0 || wb_cti_o !== 3'b000 ||
            cmd_ready !== 1'b0 || busy !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL finish_state got cyc=%b stb=%b we=%b cti=%b ready=%b busy=%b err=%b",
                     wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o, cmd_ready, busy, err);
        end
        checks++;
        if (rdata_valid !== !we) begin
            errors++; $display("FAIL last_rdata_valid got %b exp %b", rdata_valid, !we);
        end
        if (!we && rdata_valid === 1'b1 && rq.size() > 0) begin
            rcnt++;
            exp_r = rq.pop_front();
            checks++;
            if (rdata !== exp_r) begin
                errors++; $display("FAIL last_rdata got %h exp %h", rdata, exp_r);
            end
        end
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || rdata_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_return got ready=%b busy=%b rvalid=%b exp 1/0/0", cmd_ready, busy, rdata_valid);
        end
        checks++;
        if (we ? (hidx != int'(l) + 1) : (rcnt != int'(l) + 1)) begin
            errors++; $display("FAIL beat_count got %0d exp %0d", we ? hidx : rcnt, l + 1);
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
        wdata_valid = 1'b0; wdata = '0; wsel = '0; wb_ack_i = 1'b0; wb_dat_i = '0;
        repeat (3) tick();
        checks++;
        if ({cmd_ready, wdata_ready, rdata_valid, busy, err, wb_cyc_o, wb_stb_o, wb_we_o} !== 8'h00 ||
            wb_addr_o !== '0 || wb_dat_o !== '0 || wb_sel_o !== '0 || wb_cti_o !== '0 || rdata !== '0) begin
            errors++; $display("FAIL reset_outputs got ready=%b cyc=%b busy=%b addr=%h exp all 0",
                               cmd_ready, wb_cyc_o, busy, wb_addr_o);
        end
        sys_rst = 1'b0;
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_release got ready=%b busy=%b exp 1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_write4();
        int w;
        run_burst(1'b1, 26'h0000100, 8'd3, 70, 80, -1, 0, 1'b1, w);
    endtask

    task automatic test_read1_wrap();
        int w;
        run_burst(1'b0, 26'h3FFFFFF, 8'd0, 60, 0, -1, 0, 1'b1, w);
        checks++;
        if (wb_addr_o !== 26'h0000000) begin
            errors++; $display("FAIL addr_wrap got %h exp 0000000", wb_addr_o);
        end
    endtask

    task automatic test_starvation();
        int w;
        run_burst(1'b1, 26'h0000200, 8'd2, 100, 100, 1, 5, 1'b0, w);
        checks++;
        if (w < 4) begin
            errors++; $display("FAIL starve_waits got %0d exp >=4", w);
        end
    endtask

    task automatic test_max_len();
        int w;
        run_burst(1'b0, 26'h0000000, 8'd255, 100, 0, -1, 0, 1'b0, w);
    endtask

    task automatic test_back_to_back();
        int w;
        for (int i = 0; i < 12; i++) begin
            run_burst(1'($urandom), 26'($urandom), 8'($urandom_range(0, 15)),
                      $urandom_range(30, 100), $urandom_range(30, 100),
                      $urandom_range(0, 4), $urandom_range(0, 3), 1'b0, w);
        end
    endtask

    task automatic test_reset_mid_burst();
        issue_cmd(1'b1, 26'h0000100, 8'd3);
        wdata_valid = 1'b1; wdata = 32'hA0; wsel = 4'hF; wb_ack_i = 1'b1;
        tick();
        wdata = 32'hA1;
        tick();
        #1;
        checks++;
        if (wb_stb_o !== 1'b1 || wb_addr_o !== 26'h0000104) begin
            errors++; $display("FAIL mid_beat2 got stb=%b addr=%h exp 1/0000104", wb_stb_o, wb_addr_o);
        end
        sys_rst = 1'b1;
        #1;
        checks++;
        if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || busy !== 1'b0 || wdata_ready !== 1'b0) begin
            errors++; $display("FAIL async_reset got cyc=%b stb=%b busy=%b wready=%b exp 0",
                               wb_cyc_o, wb_stb_o, busy, wdata_ready);
        end
        tick();
        sys_rst = 1'b0; wdata_valid = 1'b0; wb_ack_i = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || wb_cyc_o !== 1'b0) begin
            errors++; $display("FAIL post_reset got ready=%b busy=%b cyc=%b exp 1/0/0", cmd_ready, busy, wb_cyc_o);
        end
        tick();
    endtask

    task automatic test_timeout();
        int n;
        bit seen_err;
        n = 0; seen_err = 1'b0;
        wb_ack_i = 1'b0;
        issue_cmd(1'b0, 26'($urandom), 8'd0);
`ifdef WB_BURST_TIMEOUT_EN
        for (int i = 0; i < 40 && !seen_err; i++) begin
            if (i > 0) tick();
            if (err === 1'b1) seen_err = 1'b1;
            else if (wb_stb_o === 1'b1) n++;
        end
        checks++;
        if (!seen_err || n != 16 || wb_cyc_o !== 1'b0) begin
            errors++; $display("FAIL timeout_abort got err=%b stb_cycles=%0d cyc=%b exp 1/16/0", seen_err, n, wb_cyc_o);
        end
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || err !== 1'b0) begin
            errors++; $display("FAIL timeout_idle got ready=%b err=%b exp 1/0", cmd_ready, err);
        end
`else
        for (int i = 0; i < 40; i++) begin
            if (i > 0) tick();
            if (wb_stb_o === 1'b1 && err === 1'b0) n++;
        end
        checks++;
        if (n != 40) begin
            errors++; $display("FAIL stb_hold got %0d cycles exp 40", n);
        end
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL hold_release got ready=%b busy=%b exp 1/0", cmd_ready, busy);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_write4();
        test_read1_wrap();
        test_starvation();
        test_max_len();
        test_back_to_back();
        test_reset_mid_burst();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
